rr_distributor: RTL and testbench

Round-robin one-to-four stream distributor: the fan-out counterpart of the round-robin arbiter. It accepts one decoupled (valid/ready) input stream and spreads words across four decoupled output ports in rotating order, skipping ports that cannot take data. Each output has a one-entry registered slot, so outputs are register-driven and a word is delivered one cycle after acceptance. It sits in front of replicated worker lanes that each consume a share of a single producer stream.

---
 rtl/rr_distributor_if.sv | 41 ++++
 rtl/rr_distributor.sv | 80 ++++++++
 tb/tb_rr_distributor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_distributor_if.sv
// Stream bundle for the round-robin distributor: one input stream, four output slots.
// Latency: none, signal grouping only.
// Backpressure: carries in_ready and the per-port out_ready back toward the producer.
interface rr_distributor_if #(
  parameter int WIDTH = 8
);
  // Producer side
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bits;

  // Consumer side, one bit / word per port
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [3:0][WIDTH-1:0] out_bits;

  // Port the current input offer would be steered to
  logic [1:0]            chosen;

  // Distributor side
  modport master (
    input  in_valid,
    input  in_bits,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bits,
    output chosen
  );

  // Producer / consumer environment side
  modport slave (
    output in_valid,
    output in_bits,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bits,
    input  chosen
  );
endinterface

// File: rtl/rr_distributor.sv
// Round-robin 1-to-4 stream distributor with a one-word registered slot per output.
// Latency: a word accepted on edge t is valid on its output right after edge t.
// Backpressure: in_ready drops only when every slot is full and not being drained.
module rr_distributor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  rr_distributor_if.master io
);

  logic [3:0]            slot_v;
  logic [3:0][WIDTH-1:0] slot_d;
  logic [1:0]            last_ptr;

  logic [3:0]            free;
  logic [1:0]            chosen;
  logic                  found;
  logic                  fire;

  // A slot can take a word if empty, or if its current word leaves this cycle.
  always_comb begin
    free = ~slot_v | io.out_ready;
    fire = io.in_valid & (|free);
  end

  // Pick the first free port after the last grant, wrapping to the lowest free port;
  // falls back to 3 when nothing is free (in_ready is low then, so it is never used).
  always_comb begin
    chosen = 2'd3;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && (2'(k) > last_ptr) && free[k]) begin
        chosen = 2'(k);
        found  = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (!found && free[k]) begin
        chosen = 2'(k);
        found  = 1'b1;
      end
    end
  end

  // Slot registers: a load beats a drain, so a refilled slot stays valid across the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_v <= '0;
      slot_d <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fire && (chosen == 2'(k))) begin
          slot_v[k] <= 1'b1;
          slot_d[k] <= io.in_bits;
        end else if (io.out_ready[k]) begin
          slot_v[k] <= 1'b0;
        end
      end
    end
  end

  // Last-grant pointer advances only on an accepted input word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ptr <= 2'd0;
    end else if (fire) begin
      last_ptr <= chosen;
    end
  end

  // Outputs come straight from the slot registers; only in_ready/chosen are combinational.
  always_comb begin
    io.in_ready  = |free;
    io.chosen    = chosen;
    io.out_valid = slot_v;
    io.out_bits  = slot_d;
  end

endmodule

// File: tb/tb_rr_distributor.sv
// Self-checking bench for rr_distributor: queue-free behavioural model plus directed vectors.
// Latency: model commits on each rising edge, outputs compared on each falling edge.
// Backpressure: exercised through directed out_ready patterns.
module tb_rr_distributor;

  logic clk;
  logic reset;

  rr_distributor_if #(.WIDTH(8)) io ();

  rr_distributor #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.master)
  );

  int checks = 0;
  int errors = 0;

  // Model state: which slots hold a word, their contents, last grant index
  logic [3:0] mv = 4'b0;
  logic [7:0] md [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  int         mr = 0;

  int t1_port [5] = '{1, 2, 3, 0, 1};
  int t2_port [4] = '{1, 2, 3, 0};
  int t3_port [5] = '{1, 3, 0, 1, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rotating search starting just after the last grant; 3 when no port is free.
  function automatic logic [1:0] pick(input logic [3:0] fr, input int r);
    for (int i = 1; i <= 4; i++) begin
      int p;
      p = (r + i) % 4;
      if (fr[p]) return 2'(p);
    end
    return 2'd3;
  endfunction

  task automatic model_clear();
    mv = 4'b0;
    for (int k = 0; k < 4; k++) md[k] = 8'h0;
    mr = 0;
  endtask

  // Model advance on each rising edge from the stable tb-driven inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        model_clear();
      end else begin
        logic [3:0] fr;
        logic [1:0] c;
        logic       f;
        fr = ~mv | io.out_ready;
        c  = pick(fr, mr);
        f  = io.in_valid && (fr != 4'b0);
        for (int k = 0; k < 4; k++) begin
          if (f && (int'(c) == k)) begin
            mv[k] = 1'b1;
            md[k] = io.in_bits;
          end else if (io.out_ready[k]) begin
            mv[k] = 1'b0;
          end
        end
        if (f) mr = int'(c);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      logic [3:0] fr;
      @(negedge clk);
      if (!reset) model_clear();
      fr = ~mv | io.out_ready;
      chk("cmp_in_ready", 32'(io.in_ready), 32'(fr != 4'b0));
      chk("cmp_chosen", 32'(io.chosen), 32'(pick(fr, mr)));
      chk("cmp_out_valid", 32'(io.out_valid), 32'(mv));
      for (int k = 0; k < 4; k++)
        chk("cmp_out_bits", 32'(io.out_bits[k]), 32'(md[k]));
    end
  end

  // Pull reset low between edges, confirm outputs clear without a clock, release mid-cycle.
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    io.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'h0);
    chk("rst_out_bits", 32'(io.out_bits), 32'h0);
    chk("rst_in_ready", 32'(io.in_ready), 32'h1);
    chk("rst_chosen", 32'(io.chosen), 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not end, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_bits   = 8'h00;
    io.out_ready = 4'h0;
    #2;
    chk("init_out_valid", 32'(io.out_valid), 32'h0);
    chk("init_out_bits", 32'(io.out_bits), 32'h0);
    chk("init_in_ready", 32'(io.in_ready), 32'h1);
    chk("init_chosen", 32'(io.chosen), 32'h1);
    #10;
    reset = 1'b1;

    // Round-robin order with every consumer ready
    io.out_ready = 4'hF;
    io.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      io.in_bits = 8'(8'h10 + i);
      #1;
      chk("t1_chosen", 32'(io.chosen), 32'(t1_port[i]));
      @(posedge clk);
      #1;
      chk("t1_valid", 32'(io.out_valid), 32'(4'b0001 << t1_port[i]));
      chk("t1_bits", 32'(io.out_bits[t1_port[i]]), 32'(8'h10 + i));
    end
    io.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_drained", 32'(io.out_valid), 32'h0);

    // Idle hold: pointer stays at 1, so the next offer would go to port 2
    io.in_bits = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("t6_chosen", 32'(io.chosen), 32'h2);
      chk("t6_no_load", 32'(io.out_valid), 32'h0);
      @(posedge clk);
      #1;
    end

    pulse_reset();

    // Full backpressure
    io.out_ready = 4'h0;
    io.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.in_bits = 8'(8'hA0 + i);
      #1;
      chk("t2_chosen", 32'(io.chosen), 32'(t2_port[i]));
      chk("t2_in_ready", 32'(io.in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("t2_valid", 32'(io.out_valid[t2_port[i]]), 32'h1);
      chk("t2_bits", 32'(io.out_bits[t2_port[i]]), 32'(8'hA0 + i));
    end
    chk("t2_full_ready", 32'(io.in_ready), 32'h0);
    chk("t2_full_chosen", 32'(io.chosen), 32'h3);
    chk("t2_full_valid", 32'(io.out_valid), 32'hF);
    io.in_bits = 8'hA4;
    @(posedge clk);
    #1;
    chk("t2_hold_valid", 32'(io.out_valid), 32'hF);
    chk("t2_hold_bits", 32'(io.out_bits), 32'hA2A1_A0A3);
    io.out_ready = 4'b0100;
    #1;
    chk("t2_release_chosen", 32'(io.chosen), 32'h2);
    chk("t2_release_ready", 32'(io.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("t2_a4_bits", 32'(io.out_bits[2]), 32'hA4);
    chk("t2_a4_valid", 32'(io.out_valid), 32'hF);
    io.in_valid  = 1'b0;
    io.out_ready = 4'h0;

    // Same-cycle drain and refill of slot 1
    io.out_ready = 4'b0010;
    io.in_valid  = 1'b1;
    io.in_bits   = 8'h55;
    #1;
    chk("t4_in_ready", 32'(io.in_ready), 32'h1);
    chk("t4_chosen", 32'(io.chosen), 32'h1);
    @(posedge clk);
    #1;
    chk("t4_valid", 32'(io.out_valid), 32'hF);
    chk("t4_bits", 32'(io.out_bits[1]), 32'h55);
    io.in_valid  = 1'b0;
    io.out_ready = 4'h0;

    // Asynchronous reset with all slots full, then refill 1,2,3,0 with stalled consumers
    pulse_reset();
    io.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.in_bits = 8'(8'hB0 + i);
      #1;
      chk("t5_chosen", 32'(io.chosen), 32'(t2_port[i]));
      @(posedge clk);
      #1;
      chk("t5_bits", 32'(io.out_bits[t2_port[i]]), 32'(8'hB0 + i));
    end

    // Skip the stalled port 2; its word must stay untouched
    io.out_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      io.in_bits = 8'(8'h20 + i);
      #1;
      chk("t3_chosen", 32'(io.chosen), 32'(t3_port[i]));
      @(posedge clk);
      #1;
      chk("t3_valid", 32'(io.out_valid[t3_port[i]]), 32'h1);
      chk("t3_bits", 32'(io.out_bits[t3_port[i]]), 32'(8'h20 + i));
      chk("t3_stalled_valid", 32'(io.out_valid[2]), 32'h1);
      chk("t3_stalled_bits", 32'(io.out_bits[2]), 32'hB1);
    end
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
